// File: rtl/reg_dump_tx_if.sv
// Register-dump port bundle: start request, register-file read port, UART line and status.
interface reg_dump_tx_if;
  logic        start;
  logic [4:0]  dump_addr;
  logic [31:0] dump_data;
  logic        tx;
  logic        busy;
  logic        done;

  modport master (output start, dump_data, input dump_addr, tx, busy, done);
  modport slave  (input start, dump_data, output dump_addr, tx, busy, done);
endinterface

// File: rtl/reg_dump_tx.sv
// Walks register-file entries 0..NUM_REGS-1 and sends each word MSB byte first over 8N1 UART.
// Define REG_DUMP_HDR_EN to prefix every dump with sync byte 0xA5.
module reg_dump_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int NUM_REGS     = 32
) (
  input  logic         clk,
  input  logic         rst,
  reg_dump_tx_if.slave bus
);

  localparam int             BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [4:0]     ADDR_LAST = 5'(NUM_REGS - 1);

`ifdef REG_DUMP_HDR_EN
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_LOAD, S_START, S_DATA, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t        state, state_nxt;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [1:0]    byte_idx;
  logic [31:0]   word;
  logic [4:0]    addr;
  logic          done_q;
  logic          hdr_phase;
  logic [7:0]    cur_byte;
  logic          tx_bit;
  logic          baud_end;

  assign baud_end = (baud_cnt == BAUD_LAST);

`ifdef REG_DUMP_HDR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hdr_phase <= 1'b0;
    end else if (state == S_IDLE && bus.start) begin
      hdr_phase <= 1'b1;
    end else if (state == S_STOP && baud_end) begin
      hdr_phase <= 1'b0;
    end
  end
`else
  assign hdr_phase = 1'b0;
`endif

  always_comb begin
    cur_byte = 8'hA5;
    if (!hdr_phase) begin
      case (byte_idx)
        2'd0:    cur_byte = word[31:24];
        2'd1:    cur_byte = word[23:16];
        2'd2:    cur_byte = word[15:8];
        default: cur_byte = word[7:0];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tx_bit    = 1'b1;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
`ifdef REG_DUMP_HDR_EN
          state_nxt = S_HDR;
`else
          state_nxt = S_LOAD;
`endif
        end
      end
`ifdef REG_DUMP_HDR_EN
      S_HDR:   state_nxt = S_START;
`endif
      S_LOAD:  state_nxt = S_START;
      S_START: begin
        tx_bit = 1'b0;
        if (baud_end) state_nxt = S_DATA;
      end
      S_DATA: begin
        tx_bit = cur_byte[bit_cnt];
        if (baud_end && bit_cnt == 3'd7) state_nxt = S_STOP;
      end
      S_STOP: begin
        if (baud_end) begin
          // The header's closing edge doubles as register 0's capture edge, so no LOAD cycle follows it.
          if (hdr_phase)                   state_nxt = S_START;
          else if (byte_idx != 2'd3)       state_nxt = S_START;
          else if (addr == ADDR_LAST)      state_nxt = S_IDLE;
          else                             state_nxt = S_LOAD;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_cnt <= '0;
      bit_cnt  <= 3'd0;
      byte_idx <= 2'd0;
      word     <= 32'd0;
      addr     <= 5'd0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            addr     <= 5'd0;
            byte_idx <= 2'd0;
            bit_cnt  <= 3'd0;
            baud_cnt <= '0;
          end
        end
        S_LOAD: begin
          word     <= bus.dump_data;
          byte_idx <= 2'd0;
        end
        S_START: baud_cnt <= baud_end ? '0 : baud_cnt + 1'b1;
        S_DATA: begin
          baud_cnt <= baud_end ? '0 : baud_cnt + 1'b1;
          if (baud_end) bit_cnt <= bit_cnt + 3'd1;
        end
        S_STOP: begin
          baud_cnt <= baud_end ? '0 : baud_cnt + 1'b1;
          if (baud_end) begin
            if (hdr_phase) begin
              word     <= bus.dump_data;
              byte_idx <= 2'd0;
            end else if (byte_idx == 2'd3) begin
              if (addr == ADDR_LAST) done_q <= 1'b1;
              else                   addr   <= addr + 5'd1;
            end else begin
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.tx        = tx_bit;
  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = done_q;
  assign bus.dump_addr = addr;

endmodule

// File: doc/reg_dump_tx.md
# reg_dump_tx

Debug read-out engine for the single-cycle RISC-V core's register file. On a start pulse it walks registers 0..NUM_REGS-1 through a dedicated asynchronous read port (address out, data in) and serializes each 32-bit value over a UART transmit line (8N1). It sits beside `reg_file` as the reader and off-chip reporter of architectural state, with no effect on core execution.

## Interface
Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (868 = 115200 baud at 100 MHz); legal range ≥ 2
- NUM_REGS, 32, registers dumped, indices 0..NUM_REGS-1; legal range 1..32

Ports:
- clk  input  1  system clock; all state on rising edge
- rst  input  1  reset, asynchronous, active-low (0 = reset)
- start  input  1  request a dump; sampled only in IDLE
- dump_addr  output  5  register index driven to the register-file read port
- dump_data  input  32  combinational read data for dump_addr
- tx  output  1  UART serial out, idle high
- busy  output  1  high from start acceptance until dump completes
- done  output  1  one-cycle pulse when the final stop bit ends

## Operation
- States: IDLE, HDR (macro only), LOAD, START, DATA, STOP.
- IDLE: tx=1, busy=0. start=1 at a rising edge -> busy=1, dump_addr=0, next state LOAD (or HDR if macro set).
- LOAD: one cycle; at its end dump_data is captured into a 32-bit word register, byte index=0, next state START.
- Byte send: START drives tx=0 for CLKS_PER_BIT cycles; DATA drives 8 bits LSB first, CLKS_PER_BIT each; STOP drives tx=1 for CLKS_PER_BIT.
- Byte order per register: most-significant byte first (bits 31:24, 23:16, 15:8, 7:0).
- After STOP of byte 3: if dump_addr = NUM_REGS-1 -> IDLE, done=1 for one cycle, busy=0; else dump_addr+1 -> LOAD.
- start while busy=1: ignored, no queuing. start held high: a new dump begins on the edge after done.
- Capture is per register, not atomic: a register written after its LOAD is reported with its pre-write value; one written before its LOAD is reported with the new value.
- Bit counter and baud counter are sized for CLKS_PER_BIT-1 and 7; no wrap beyond these.

## Timing
- Reset (async assert): tx=1, busy=0, done=0, dump_addr=0, state IDLE, counters 0, within no clock edge. Reset mid-frame truncates the byte; tx returns high immediately.
- Start accepted at edge k: busy=1 after k; without macro, tx falls (start bit) after edge k+1.
- Per register: 1 + 40*CLKS_PER_BIT cycles.
- done high for the cycle following edge k + NUM_REGS*(1+40*CLKS_PER_BIT) (plus 10*CLKS_PER_BIT with macro); busy falls on the same edge.
- dump_addr is registered, stable throughout each register's LOAD and transmission.

## Configuration
- REG_DUMP_HDR_EN defined: on acceptance enter HDR, transmit sync byte 0xA5 (8N1, 10*CLKS_PER_BIT cycles) before the LOAD of register 0; tx falls after edge k+1 for the header start bit.
- Not defined: no header; HDR state absent; first byte is bits 31:24 of register 0.

## Test plan
- Reset: drive rst=0 with clock stopped -> tx=1, busy=0, done=0, dump_addr=0 immediately.
- CLKS_PER_BIT=4, macro off, reg9=0x46A1F1B7, reg18=0xFFFF0000, others 0, start at edge k -> decoded stream bytes 36..39 = 46 A1 F1 B7, bytes 72..75 = FF FF 00 00, all others 00; done pulse after edge k+5152.
- Pulse start again at k+100 during dump -> ignored; exactly one done pulse, 128 bytes total.
- Assert rst mid-DATA of register 5 -> tx=1, busy=0 asynchronously; subsequent start restarts from dump_addr=0 with full 128-byte stream.
- Macro on, same setup -> first byte 0xA5, then 128 register bytes; done after edge k+5192.
- Write reg3 to 0x12345678 while dump_addr=1 -> reg3 reported as 12 34 56 78; write reg1 during its transmission -> old value reported.
